sdram_rr_arbiter: RTL and testbench
===================================

// Module: sdram_rr_arbiter
// PURPOSE
//  Two-master round-robin arbiter in front of the SoC's single SDRAM controller slave port (Avalon-MM, pipelined reads).
//  Lets the LED/switch accumulate datapath (m0) and the frame-copy engine (m1) share the 16-bit SDRAM.
//  Tracks outstanding reads in an ID FIFO and steers each readdatavalid back to the master that issued the read.
// PARAMETERS
//  ADDR_W    25  word address width (32M x16 SDRAM)
//  DATA_W    16  data width; byteenable width = DATA_W/8
//  MAX_PEND  8   max outstanding reads (ID FIFO depth, power of 2, >=2)
// PORTS
//  clk_clk               in   1        system clock, all logic rising-edge
//  reset_reset_n         in   1        synchronous, active-low reset
//  m{0,1}_address        in   ADDR_W   master word address
//  m{0,1}_read/_write    in   1        master command, held until waitrequest=0
//  m{0,1}_writedata      in   DATA_W   write data
//  m{0,1}_byteenable     in   DATA_W/8 byte lanes
//  m{0,1}_waitrequest    out  1        1 = command not accepted this cycle
//  m{0,1}_readdata       out  DATA_W   broadcast of s_readdata
//  m{0,1}_readdatavalid  out  1        read return for this master
//  s_address/_writedata/_byteenable  out  as master   muxed command to SDRAM controller
//  s_read/_write         out  1        command strobe
//  s_waitrequest         in   1        controller stall
//  s_readdata            in   DATA_W   return data
//  s_readdatavalid       in   1        one return beat, in issue order
//  err_unexp_rdv         out  1        sticky: readdatavalid seen with ID FIFO empty
// BEHAVIOUR
//  Reset: FSM=IDLE, rr_last=1 (m0 wins first tie), FIFO empty, err=0; s_read=s_write=0,
//   m*_waitrequest=1, m*_readdatavalid=0. Reset mid-transfer drops all outstanding IDs.
//  FSM IDLE/GNT0/GNT1, registered grant:
//   IDLE: req_x = m_x_read|m_x_write. One requester -> GNTx; both -> GNT(!rr_last). None -> IDLE.
//   GNTx: forward m_x command to s_*. On accept (s_cmd & !s_waitrequest): rr_last<=x; next state =
//    GNTy if other master requesting, else GNTx if m_x still requesting (sampled same cycle), else IDLE.
//   Grant never changes while the owner's command is unaccepted (no switch under waitrequest).
//  Latency: request in IDLE at cycle t -> s_* valid at t+1. Back-to-back and switches: zero bubble.
//  Read gating: in GNTx with m_x_read and FIFO full, s_read=0, m_x_waitrequest=1 until a pop.
//   Push allowed only when count<MAX_PEND (registered count; no push-on-full even with simultaneous pop).
//  m_x_waitrequest = !(state==GNTx & s_waitrequest==0 & s_cmd); non-owner always 1.
//  s_read and s_write are never both 1; master asserting both: read takes precedence, write held.
//  ID FIFO: push owner ID on accepted read; pop on s_readdatavalid. Push+pop same cycle: count unchanged.
//  Return routing (combinational): m_h_readdatavalid = s_readdatavalid & FIFO head==h; other master 0.
//  s_readdatavalid with FIFO empty: no master gets valid, err_unexp_rdv<=1 until reset.
//  Idle slave outputs: address/writedata/byteenable hold last owner value, strobes 0.
// STRUCTURE
//  Package sdram_arb_pkg: ADDR_W/DATA_W defaults, state enum {IDLE,GNT0,GNT1}, 1-bit master_id_t.
//  Sub-module arb_id_fifo: synchronous FIFO, width 1, depth MAX_PEND, outputs full/empty/head/count.
//  Top: FSM + rr_last register + command mux + return demux.
// TESTING
//  1 m0 write 0x0001A5 data 0x1234, s_waitrequest=0 -> s_write at t+1, m0_waitrequest=0 that cycle, m1 untouched.
//  2 m0,m1 both read every cycle, controller never stalls -> s_address alternates m0,m1,m0...; m0 first after reset.
//  3 m1 reads 3 addrs, readdatavalid returns 3 beats 2 cycles later -> only m1_readdatavalid pulses, data 0xBEEF,0xCAFE,0x0F0F.
//  4 9 reads from m0, no returns (MAX_PEND=8) -> 8 accepted, 9th held with m0_waitrequest=1; one return -> 9th accepted next cycle.
//  5 s_waitrequest=1 for 5 cycles on m0 read while m1 requests -> grant stays GNT0, s_address stable, m1 served after accept.
//  6 s_readdatavalid with no reads pending -> err_unexp_rdv=1 sticky; reset_reset_n=0 one cycle -> err=0, waitrequests=1.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-master SDRAM round-robin arbiter.
package sdram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 25;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } arb_state_t;

    typedef logic master_id_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Outstanding-read ID FIFO: remembers which master issued each accepted read, in issue order.
module arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  master_id_t       id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output master_id_t       head_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    master_id_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the registered count, so a same-cycle pop never makes room for a push.
    assign push_ok = push_i && (count_q < FULL_CNT);
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= id_i;
    end

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM slave between two masters,
// with pipelined-read return routing via an ID FIFO.
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_PEND = 8,
    localparam int unsigned BE_W    = DATA_W / 8,
    localparam int unsigned CNT_W   = $clog2(MAX_PEND) + 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic              err_unexp_rdv
);

    arb_state_t        state_q, state_d;
    master_id_t        rr_last_q, rr_last_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
    logic [BE_W-1:0]   hold_be_q, hold_be_d;

    logic              req0, req1;
    master_id_t        owner;
    logic              own_req, oth_req, own_read, own_write, accept;
    logic              fifo_push, fifo_full, fifo_empty;
    master_id_t        fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    assign owner     = (state_q == GNT1);
    assign own_req   = owner ? req1 : req0;
    assign oth_req   = owner ? req0 : req1;
    assign own_read  = owner ? m1_read : m0_read;
    assign own_write = owner ? m1_write : m0_write;

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_be_d    = hold_be_q;
        s_read       = 1'b0;
        s_write      = 1'b0;
        accept       = 1'b0;
        fifo_push    = 1'b0;

        if (state_q == IDLE) begin
            if (req0 && req1) state_d = rr_last_q ? GNT0 : GNT1;
            else if (req0)    state_d = GNT0;
            else if (req1)    state_d = GNT1;
        end else begin
            hold_addr_d  = owner ? m1_address   : m0_address;
            hold_wdata_d = owner ? m1_writedata : m0_writedata;
            hold_be_d    = owner ? m1_byteenable : m0_byteenable;
            // Read wins over a simultaneous write; reads stall while the ID FIFO is full.
            s_read    = own_read && !fifo_full;
            s_write   = own_write && !own_read;
            accept    = (s_read || s_write) && !s_waitrequest;
            fifo_push = s_read && !s_waitrequest;
            if (accept) begin
                rr_last_d = owner;
                if (oth_req)      state_d = owner ? GNT0 : GNT1;
                else if (own_req) state_d = state_q;
                else              state_d = IDLE;
            end else if (!own_req) begin
                // Owner dropped its request without a pending command: release so the other side is not locked out.
                state_d = oth_req ? (owner ? GNT0 : GNT1) : IDLE;
            end
        end
    end

    assign s_address    = (state_q == GNT0) ? m0_address    : (state_q == GNT1) ? m1_address    : hold_addr_q;
    assign s_writedata  = (state_q == GNT0) ? m0_writedata  : (state_q == GNT1) ? m1_writedata  : hold_wdata_q;
    assign s_byteenable = (state_q == GNT0) ? m0_byteenable : (state_q == GNT1) ? m1_byteenable : hold_be_q;

    assign m0_waitrequest = !(accept && (state_q == GNT0));
    assign m1_waitrequest = !(accept && (state_q == GNT1));

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid && !fifo_empty && (fifo_head == 1'b0);
    assign m1_readdatavalid = s_readdatavalid && !fifo_empty && (fifo_head == 1'b1);

    assign err_d         = err_q | (s_readdatavalid && (fifo_count == '0));
    assign err_unexp_rdv = err_q;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            err_q        <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_be_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            err_q        <= err_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_be_q    <= hold_be_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_PEND)
    ) u_id_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (fifo_push),
        .id_i    (owner),
        .pop_i   (s_readdatavalid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter: grant order, stalls, ID FIFO limits and return routing.
module tb_sdram_rr_arbiter;

    localparam int unsigned AW = 25;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]    m0_byteenable, m1_byteenable, s_byteenable;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [DW-1:0] s_readdata;
    logic          err_unexp_rdv;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    sdram_rr_arbiter dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .err_unexp_rdv    (err_unexp_rdv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        logic [AW-1:0] t3_addr [6];
        logic [DW-1:0] t3_data [6];
        t3_addr = '{25'h10, 25'h10, 25'h11, 25'h12, 25'h0, 25'h0};
        t3_data = '{16'h0, 16'h0, 16'h0, 16'hBEEF, 16'hCAFE, 16'h0F0F};

        // Reset state
        do_reset();
        sample();
        check("rst_m0_wr", m0_waitrequest, 1);
        check("rst_m1_wr", m1_waitrequest, 1);
        check("rst_s_read", s_read, 0);
        check("rst_s_write", s_write, 0);
        check("rst_err", err_unexp_rdv, 0);
        check("rst_m0_rdv", m0_readdatavalid, 0);
        step();

        // 1: single m0 write
        m0_write = 1'b1; m0_address = 25'h0001A5; m0_writedata = 16'h1234; m0_byteenable = 2'b11;
        sample();
        check("t1_idle_s_write", s_write, 0);
        check("t1_idle_m0_wr", m0_waitrequest, 1);
        step();
        sample();
        check("t1_s_write", s_write, 1);
        check("t1_s_read", s_read, 0);
        check("t1_s_addr", s_address, 32'h1A5);
        check("t1_s_wdata", s_writedata, 32'h1234);
        check("t1_s_be", s_byteenable, 3);
        check("t1_m0_wr", m0_waitrequest, 0);
        check("t1_m1_wr", m1_waitrequest, 1);
        step();
        m0_write = 1'b0;
        sample();
        check("t1_drop_s_write", s_write, 0);
        check("t1_drop_m0_wr", m0_waitrequest, 1);
        step();
        sample();
        check("t1_hold_addr", s_address, 32'h1A5);
        check("t1_hold_strobe", s_write, 0);
        step();

        // 2: both masters read every cycle, alternating, m0 first
        do_reset();
        m0_read = 1'b1; m0_address = 25'h100;
        m1_read = 1'b1; m1_address = 25'h200;
        sample();
        step();
        for (int i = 0; i < 4; i++) begin
            sample();
            check("t2_s_read", s_read, 1);
            check("t2_s_addr", s_address, (i % 2 == 0) ? 32'h100 : 32'h200);
            check("t2_m0_wr", m0_waitrequest, (i % 2 == 0) ? 0 : 1);
            check("t2_m1_wr", m1_waitrequest, (i % 2 == 0) ? 1 : 0);
            step();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        sample();
        step();
        for (int i = 0; i < 4; i++) begin
            s_readdatavalid = 1'b1; s_readdata = 16'(16'h1000 + i);
            sample();
            check("t2_m0_rdv", m0_readdatavalid, (i % 2 == 0) ? 1 : 0);
            check("t2_m1_rdv", m1_readdatavalid, (i % 2 == 0) ? 0 : 1);
            check("t2_rdata", (i % 2 == 0) ? m0_readdata : m1_readdata, 32'h1000 + i);
            step();
        end
        s_readdatavalid = 1'b0;
        sample();
        check("t2_err", err_unexp_rdv, 0);
        step();

        // 3: m1 reads three addresses, data returns two cycles after issue
        do_reset();
        for (int c = 0; c < 6; c++) begin
            m1_read = (c <= 3);
            m1_address = t3_addr[c];
            s_readdatavalid = (c >= 3);
            s_readdata = t3_data[c];
            sample();
            if (c >= 1 && c <= 3) begin
                check("t3_s_read", s_read, 1);
                check("t3_s_addr", s_address, 32'(t3_addr[c]));
            end
            check("t3_m1_rdv", m1_readdatavalid, (c >= 3) ? 1 : 0);
            check("t3_m0_rdv", m0_readdatavalid, 0);
            if (c >= 3) check("t3_m1_rdata", m1_readdata, 32'(t3_data[c]));
            step();
        end
        clear_inputs();
        sample();
        check("t3_err", err_unexp_rdv, 0);
        step();

        // 4: nine reads from m0, eight outstanding max
        do_reset();
        m0_read = 1'b1; m0_address = 25'h300;
        sample();
        step();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (!m0_waitrequest) acc++;
            step();
        end
        check("t4_accepted", acc, 8);
        s_readdatavalid = 1'b1; s_readdata = 16'h4444;
        sample();
        check("t4_full_s_read", s_read, 0);
        check("t4_full_m0_wr", m0_waitrequest, 1);
        check("t4_pop_m0_rdv", m0_readdatavalid, 1);
        step();
        s_readdatavalid = 1'b0;
        sample();
        check("t4_ninth_s_read", s_read, 1);
        check("t4_ninth_m0_wr", m0_waitrequest, 0);
        check("t4_ninth_addr", s_address, 32'h300);
        step();

        // 5: m0 read stalled five cycles while m1 waits for a write
        do_reset();
        m0_read = 1'b1; m0_address = 25'h400;
        m1_write = 1'b1; m1_address = 25'h500; m1_writedata = 16'h5555; m1_byteenable = 2'b01;
        s_waitrequest = 1'b1;
        sample();
        step();
        for (int i = 0; i < 5; i++) begin
            sample();
            check("t5_stall_s_read", s_read, 1);
            check("t5_stall_addr", s_address, 32'h400);
            check("t5_stall_m0_wr", m0_waitrequest, 1);
            check("t5_stall_m1_wr", m1_waitrequest, 1);
            check("t5_stall_s_write", s_write, 0);
            step();
        end
        s_waitrequest = 1'b0;
        sample();
        check("t5_acc_m0_wr", m0_waitrequest, 0);
        check("t5_acc_s_read", s_read, 1);
        step();
        m0_read = 1'b0;
        sample();
        check("t5_m1_s_write", s_write, 1);
        check("t5_m1_s_read", s_read, 0);
        check("t5_m1_addr", s_address, 32'h500);
        check("t5_m1_wdata", s_writedata, 32'h5555);
        check("t5_m1_wr", m1_waitrequest, 0);
        step();
        m1_write = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 16'hA0A0;
        sample();
        check("t5_ret_m0_rdv", m0_readdatavalid, 1);
        check("t5_ret_m1_rdv", m1_readdatavalid, 0);
        step();
        s_readdatavalid = 1'b0;

        // 6: unexpected return sets a sticky error, cleared only by reset
        s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
        sample();
        check("t6_m0_rdv", m0_readdatavalid, 0);
        check("t6_m1_rdv", m1_readdatavalid, 0);
        check("t6_err_pre", err_unexp_rdv, 0);
        step();
        s_readdatavalid = 1'b0;
        sample();
        check("t6_err_set", err_unexp_rdv, 1);
        step();
        step();
        sample();
        check("t6_err_sticky", err_unexp_rdv, 1);
        step();
        m0_read = 1'b1; m0_address = 25'h600;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sample();
        check("t6_rst_err", err_unexp_rdv, 0);
        check("t6_rst_m0_wr", m0_waitrequest, 1);
        check("t6_rst_m1_wr", m1_waitrequest, 1);
        check("t6_rst_s_read", s_read, 0);
        step();
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
